// File: rtl/mp3player_soc_switch_debouncer_if.sv
// Switch-side signal bundle for the slide-switch debouncer: raw pins in,
// clean levels and edge pulses out.
interface mp3player_soc_switch_debouncer_if #(
    parameter int WIDTH = 10
);
    logic [WIDTH-1:0] raw_sw;
    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic             any_change;

    modport master (
        output raw_sw,
        input  debounced,
        input  rise,
        input  fall,
        input  any_change
    );

    modport slave (
        input  raw_sw,
        output debounced,
        output rise,
        output fall,
        output any_change
    );
endinterface

// File: rtl/mp3player_soc_switch_debouncer.sv
// Per-bit two-flop synchronizer plus counting debouncer for the board slide
// switches; emits registered clean levels and one-cycle rise/fall pulses.
module mp3player_soc_switch_debouncer #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic                               clk,
    input  logic                               reset_n,
    mp3player_soc_switch_debouncer_if.slave    sw
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] s1_r;
    logic [WIDTH-1:0] s2_r;
    logic [WIDTH-1:0] deb_r;
    logic [WIDTH-1:0] rise_r;
    logic [WIDTH-1:0] fall_r;
    logic             any_r;
    logic [CNT_W-1:0] cnt_r     [WIDTH];

    logic [WIDTH-1:0] deb_nxt_s;
    logic [WIDTH-1:0] rise_nxt_s;
    logic [WIDTH-1:0] fall_nxt_s;
    logic             any_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s [WIDTH];

    // Per-bit qualification: count consecutive disagreement cycles, accept at the limit.
    always_comb begin
        deb_nxt_s  = deb_r;
        rise_nxt_s = {WIDTH{1'b0}};
        fall_nxt_s = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt_s[i] = {CNT_W{1'b0}};
            if (s2_r[i] == deb_r[i]) begin
                cnt_nxt_s[i] = {CNT_W{1'b0}};
            end else if (cnt_r[i] != CNT_LAST) begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end else begin
                // Acceptance clears the count so it can never wrap.
                deb_nxt_s[i]  = s2_r[i];
                rise_nxt_s[i] = s2_r[i];
                fall_nxt_s[i] = ~s2_r[i];
                cnt_nxt_s[i]  = {CNT_W{1'b0}};
            end
        end
        any_nxt_s = |(rise_nxt_s | fall_nxt_s);
    end

    // Synchronizer, counters and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_r   <= {WIDTH{1'b0}};
            s2_r   <= {WIDTH{1'b0}};
            deb_r  <= {WIDTH{1'b0}};
            rise_r <= {WIDTH{1'b0}};
            fall_r <= {WIDTH{1'b0}};
            any_r  <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= {CNT_W{1'b0}};
            end
        end else begin
            s1_r   <= sw.raw_sw;
            s2_r   <= s1_r;
            deb_r  <= deb_nxt_s;
            rise_r <= rise_nxt_s;
            fall_r <= fall_nxt_s;
            any_r  <= any_nxt_s;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    assign sw.debounced  = deb_r;
    assign sw.rise       = rise_r;
    assign sw.fall       = fall_r;
    assign sw.any_change = any_r;

endmodule

// File: tb/tb_mp3player_soc_switch_debouncer.sv
// Bench for the switch debouncer: a DEBOUNCE_CYCLES=4 instance driven by a
// vector table and a DEBOUNCE_CYCLES=1 instance, both checked via a scoreboard.
module tb_mp3player_soc_switch_debouncer;

    localparam int W = 10;

    typedef struct {
        logic [W-1:0] deb;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
        logic         any;
    } exp_t;

    typedef struct {
        logic [W-1:0] raw;
        int           hold;
        logic [W-1:0] deb_before;
        logic [W-1:0] deb_after;
        int           acc_edge;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } vec_t;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;

    exp_t sb_q[$];
    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    mp3player_soc_switch_debouncer_if #(.WIDTH(W)) m_if ();
    mp3player_soc_switch_debouncer_if #(.WIDTH(W)) n_if ();

    mp3player_soc_switch_debouncer #(
        .WIDTH(W), .DEBOUNCE_CYCLES(4), .CNT_W(20)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .sw(m_if)
    );

    mp3player_soc_switch_debouncer #(
        .WIDTH(W), .DEBOUNCE_CYCLES(1), .CNT_W(20)
    ) u_min (
        .clk(clk), .reset_n(reset_n), .sw(n_if)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [W-1:0] deb, input logic [W-1:0] rise,
                                input logic [W-1:0] fall, input logic any);
        exp_t e;
        e.deb  = deb;
        e.rise = rise;
        e.fall = fall;
        e.any  = any;
        return e;
    endfunction

    task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // One clock: drive inputs on the falling edge, push the expectation,
    // then pop and compare just after the rising edge.
    task automatic step(input bit sel, input logic rst, input logic [W-1:0] raw, input exp_t e);
        exp_t got;
        @(negedge clk);
        reset_n = rst;
        if (sel) n_if.raw_sw = raw;
        else     m_if.raw_sw = raw;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 required=1");
        end else begin
            got = sb_q.pop_front();
            if (sel) begin
                cmp("min_debounced", n_if.debounced, got.deb);
                cmp("min_rise",      n_if.rise,      got.rise);
                cmp("min_fall",      n_if.fall,      got.fall);
                cmp("min_any",       {{(W-1){1'b0}}, n_if.any_change}, {{(W-1){1'b0}}, got.any});
            end else begin
                cmp("debounced",  m_if.debounced, got.deb);
                cmp("rise",       m_if.rise,      got.rise);
                cmp("fall",       m_if.fall,      got.fall);
                cmp("any_change", {{(W-1){1'b0}}, m_if.any_change}, {{(W-1){1'b0}}, got.any});
            end
        end
    endtask

    // Apply one table record: raw held for 'hold' edges, acceptance at 'acc_edge' (0 = none).
    task automatic run_vec(input bit sel, input vec_t v);
        exp_t e;
        for (int k = 1; k <= v.hold; k++) begin
            e.deb  = (v.acc_edge != 0 && k >= v.acc_edge) ? v.deb_after : v.deb_before;
            e.rise = (k == v.acc_edge) ? v.rise : {W{1'b0}};
            e.fall = (k == v.acc_edge) ? v.fall : {W{1'b0}};
            e.any  = (k == v.acc_edge);
            step(sel, 1'b1, v.raw, e);
        end
    endtask

    initial begin
        exp_t z;
        exp_t e;
        z = mk(10'h000, 10'h000, 10'h000, 1'b0);

        // Reset release with all switches high, clean steps, bounce, simultaneous bits.
        vecs.push_back('{10'h3FF, 32'd8, 10'h000, 10'h3FF, 32'd6, 10'h3FF, 10'h000});
        vecs.push_back('{10'h000, 32'd8, 10'h3FF, 10'h000, 32'd6, 10'h000, 10'h3FF});
        vecs.push_back('{10'h008, 32'd8, 10'h000, 10'h008, 32'd6, 10'h008, 10'h000});
        vecs.push_back('{10'h000, 32'd8, 10'h008, 10'h000, 32'd6, 10'h000, 10'h008});
        vecs.push_back('{10'h001, 32'd3, 10'h000, 10'h000, 32'd0, 10'h000, 10'h000});
        vecs.push_back('{10'h000, 32'd1, 10'h000, 10'h000, 32'd0, 10'h000, 10'h000});
        vecs.push_back('{10'h001, 32'd8, 10'h000, 10'h001, 32'd6, 10'h001, 10'h000});
        vecs.push_back('{10'h000, 32'd8, 10'h001, 10'h000, 32'd6, 10'h000, 10'h001});
        vecs.push_back('{10'h082, 32'd8, 10'h000, 10'h082, 32'd6, 10'h082, 10'h000});
        vecs.push_back('{10'h000, 32'd8, 10'h082, 10'h000, 32'd6, 10'h000, 10'h082});

        m_if.raw_sw = 10'h3FF;
        n_if.raw_sw = 10'h000;
        #1 reset_n = 1'b0;

        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 10'h3FF, z);

        foreach (vecs[i]) run_vec(1'b0, vecs[i]);

        // Bit 1 changes at cycle 0, bit 7 two cycles later: separate pulses.
        step(1'b0, 1'b1, 10'h002, z);
        step(1'b0, 1'b1, 10'h002, z);
        for (int k = 3; k <= 10; k++) begin
            if (k < 6)       e = z;
            else if (k == 6) e = mk(10'h002, 10'h002, 10'h000, 1'b1);
            else if (k == 7) e = mk(10'h002, 10'h000, 10'h000, 1'b0);
            else if (k == 8) e = mk(10'h082, 10'h080, 10'h000, 1'b1);
            else             e = mk(10'h082, 10'h000, 10'h000, 1'b0);
            step(1'b0, 1'b1, 10'h082, e);
        end
        run_vec(1'b0, '{10'h000, 32'd8, 10'h082, 10'h000, 32'd6, 10'h000, 10'h082});

        // Reset pulsed while bit 5 has counted to 2; re-qualification starts from zero.
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 10'h020, z);
        step(1'b0, 1'b0, 10'h020, z);
        step(1'b0, 1'b0, 10'h020, z);
        run_vec(1'b0, '{10'h020, 32'd8, 10'h000, 10'h020, 32'd6, 10'h020, 10'h000});
        run_vec(1'b0, '{10'h000, 32'd8, 10'h020, 10'h000, 32'd6, 10'h000, 10'h020});

        // Single-cycle qualification: acceptance at edge 3.
        run_vec(1'b1, '{10'h200, 32'd4, 10'h000, 10'h200, 32'd3, 10'h200, 10'h000});
        run_vec(1'b1, '{10'h000, 32'd4, 10'h200, 10'h000, 32'd3, 10'h000, 10'h200});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mp3player_soc_switch_debouncer.md
# mp3player_soc_switch_debouncer

Per-bit synchronizer and debouncer for the ten board slide switches. Sits directly upstream of the switches PIO: its `debounced` output drives the PIO `in_port`, so software reads only clean, metastability-free levels. Also produces one-cycle rise/fall/change pulses for future edge-capture or interrupt logic.

## Interface
- `WIDTH`, 10 — number of switch bits.
- `DEBOUNCE_CYCLES`, 500000 — consecutive stable cycles required before a level is accepted (10 ms at 50 MHz); legal range 1 to 2^20.
- `CNT_W`, 20 — per-bit counter width; must satisfy 2^CNT_W ≥ DEBOUNCE_CYCLES.
- `clk`  in  1 — system clock; all state updates on its rising edge.
- `reset_n`  in  1 — asynchronous, active-low reset.
- `raw_sw`  in  WIDTH — asynchronous switch pins.
- `debounced`  out  WIDTH — accepted, stable switch levels; registered; connects to the PIO `in_port`.
- `rise`  out  WIDTH — one-cycle pulse per bit when `debounced[i]` goes 0→1.
- `fall`  out  WIDTH — one-cycle pulse per bit when `debounced[i]` goes 1→0.
- `any_change`  out  1 — one-cycle pulse, OR of `rise | fall` for the same cycle.

## Operation
- Synchronizer: two flops per bit, `s1 <= raw_sw`, `s2 <= s1`. Only `s2` is used downstream.
- Per-bit counter `cnt[i]` (CNT_W bits), independent across bits:
  - `s2[i] == debounced[i]`: `cnt[i] <= 0`.
  - `s2[i] != debounced[i]` and `cnt[i] < DEBOUNCE_CYCLES-1`: `cnt[i] <= cnt[i]+1`.
  - `s2[i] != debounced[i]` and `cnt[i] == DEBOUNCE_CYCLES-1`: `debounced[i] <= s2[i]`, `cnt[i] <= 0`, pulse `rise[i]` or `fall[i]` for that cycle.
- The counter never wraps; it is cleared on every acceptance and on every agreement cycle.
- Glitch rejection: any cycle where `s2[i]` matches `debounced[i]` restarts the count; a bounce shorter than DEBOUNCE_CYCLES never reaches `debounced`.
- `rise`, `fall`, `any_change` are registered and assert in the same cycle `debounced` takes its new value; they are 0 in all other cycles.
- Simultaneous events: several bits may accept in the same cycle; each gets its own pulse, `any_change` is a single pulse.
- DEBOUNCE_CYCLES = 1: a mismatch is accepted on the first mismatching edge (pure 2-flop synchronizer plus one register).

## Timing
- Reset (async assert, sync-to-clock deassert assumed from system reset logic): `s1`, `s2`, `debounced`, `cnt`, `rise`, `fall`, `any_change` all 0.
- Latency: with `raw_sw[i]` changed and held before edge 1, `s1` updates at edge 1, `s2` at edge 2, and `debounced[i]` plus its pulse update at edge DEBOUNCE_CYCLES+2.
- Reset mid-count: the count is discarded; after release, a held level is re-qualified from zero and takes the full DEBOUNCE_CYCLES+2 edges.
- Switches held high through reset: `debounced` rises DEBOUNCE_CYCLES+2 edges after release, with a `rise` pulse, because the reset value is 0.
- PIO readback of a new level: one further cycle through the PIO `readdata` register.

## Test plan
- Reset: DEBOUNCE_CYCLES=4, `raw_sw`=10'h3FF during reset -> all outputs 0 during reset; `debounced`=10'h3FF at edge 6 after release; `rise`=10'h3FF and `any_change`=1 for exactly that one cycle.
- Clean step: DEBOUNCE_CYCLES=4, bit 3 goes 0→1 and is held -> `debounced[3]`=1 at edge 6, `rise[3]` pulses once; later 1→0 produces `fall[3]` at edge 6 after the change.
- Bounce: bit 0 toggles high for 3 cycles, low for 1 cycle, then high and holds -> no acceptance during the bounce; `debounced[0]` rises 6 edges after the final transition.
- Independent bits: bit 1 changes at cycle 0 and bit 7 at cycle 2 -> accepted at edges 6 and 8 respectively; two separate `any_change` pulses. Both bits changed in the same cycle -> one `any_change` pulse, `rise`=10'h082.
- Reset mid-count: bit 5 held high, `reset_n` pulsed low at count 2 -> `debounced[5]` stays 0 and rises 6 edges after reset release.
- Minimum setting: DEBOUNCE_CYCLES=1, bit 9 changes -> `debounced[9]` updates at edge 3 with a one-cycle `rise[9]` pulse.
